// File: rtl/reg32_serializer_pkg.sv
// Shared definitions for the register-link serializer and its receiver.
package reg32_pkg;

  // FSM state encoding: IDLE waits for a word, SHIFT streams one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Default word width of the register link.
  localparam int DEFAULT_WIDTH = 32;

  // Counter width for the default word width.
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  // Counter width for an arbitrary word width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/reg32_serializer_if.sv
// Load handshake and serial output bundle of the register-link transmitter.
interface reg32_serializer_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  // Producer / observer side: supplies words and watches the serial stream.
  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  done
  );

  // Serializer side: accepts words and drives the serial stream.
  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output done
  );

endinterface

// File: rtl/reg32_serializer_bit_counter.sv
// Modulo-MOD bit counter with clear-to-zero, enable and terminal count.
// Shared by the serializer and the matching deserializer.
module bit_counter #(
  parameter int MOD = 32,
  parameter int W   = (MOD < 2) ? 1 : $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         tc;

  assign tc = (cnt_q == W'(MOD - 1));

  // Next count: clear wins, otherwise advance and wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc;

endmodule

// File: rtl/reg32_serializer.sv
// Parallel-in / serial-out transmitter for one register word per handshake.
// The word is shifted out one bit per clock, back-to-back words run gapless.
module reg32_serializer
  import reg32_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  reg32_serializer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             valid_q;
  logic             done_q;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;

  // The last bit of a word is on the line while SHIFT sits at the terminal count.
  assign last_bit  = (state_q == ST_SHIFT) && tc;
  assign ready     = !rst && ((state_q == ST_IDLE) || last_bit);
  assign accept    = bus.load_valid && ready;
  assign cnt_en    = (state_q == ST_SHIFT);
  assign cnt_clear = accept || last_bit;

  bit_counter #(
    .MOD (WIDTH),
    .W   (CW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

  // Shift towards the output end, zero-filling so an emptied register reads 0.
  always_comb begin
    shreg_d = shreg_q;
    if (MSB_FIRST) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // FSM plus shift register and registered valid/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_SHIFT;
            shreg_q <= bus.din;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (tc) begin
            if (accept) begin
              shreg_q <= bus.din;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              shreg_q <= shreg_d;
              valid_q <= 1'b0;
            end
          end else begin
            shreg_q <= shreg_d;
            valid_q <= 1'b1;
            done_q  <= (cnt == CW'(WIDTH - 2));
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = ready;
  assign bus.sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.sout_valid = valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_reg32_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer see the same
// stimulus; expected bits are queued on each predicted accept and popped
// every cycle the outputs are sampled.
module tb_reg32_serializer;

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  logic clk;
  logic rst;

  reg32_serializer_if #(.WIDTH(32)) ifM ();
  reg32_serializer_if #(.WIDTH(32)) ifL ();

  reg32_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dutM (
    .clk (clk),
    .rst (rst),
    .bus (ifM)
  );

  reg32_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dutL (
    .clk (clk),
    .rst (rst),
    .bus (ifL)
  );

  exp_t qM[$];
  exp_t qL[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   doneCntM = 0, doneCntL = 0;
  int   runM = 0, maxRunM = 0, runL = 0, maxRunL = 0;
  logic lastAccept = 1'b0;

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one instance's sampled outputs against its scoreboard, then update the model.
  task automatic checkInst(input bit lsb, input logic rdy, input logic v, input logic s,
                           input logic dn, input logic r, input logic lv, input logic [31:0] d);
    logic expRdy, expV, expS, expD, acc;
    int   qs;
    exp_t e;
    string nm;
    nm = lsb ? "lsb" : "msb";
    qs = lsb ? qL.size() : qM.size();
    expRdy = !r && (qs <= 1);
    vectors++;
    if (rdy !== expRdy) begin
      miscompares++;
      $display("[TB] FAIL %s load_ready: got %b want %b at %0t", nm, rdy, expRdy, $time);
    end
    if (qs > 0) begin
      e = lsb ? qL.pop_front() : qM.pop_front();
      expV = 1'b1; expS = e.b; expD = e.d;
    end else begin
      expV = 1'b0; expS = 1'b0; expD = 1'b0;
    end
    vectors++;
    if (v !== expV) begin
      miscompares++;
      $display("[TB] FAIL %s sout_valid: got %b want %b at %0t", nm, v, expV, $time);
    end
    vectors++;
    if (s !== expS) begin
      miscompares++;
      $display("[TB] FAIL %s sout: got %b want %b at %0t", nm, s, expS, $time);
    end
    vectors++;
    if (dn !== expD) begin
      miscompares++;
      $display("[TB] FAIL %s done: got %b want %b at %0t", nm, dn, expD, $time);
    end
    acc = lv && expRdy;
    lastAccept = acc;
    if (r) begin
      if (lsb) qL.delete(); else qM.delete();
    end else if (acc) begin
      for (int i = 0; i < 32; i++) begin
        e.b = lsb ? d[i] : d[31-i];
        e.d = (i == 31);
        if (lsb) qL.push_back(e); else qM.push_back(e);
      end
    end
  endtask

  // One clock: drive inputs after the rising edge, sample on the falling edge.
  task automatic applyStimulus(input logic r, input logic lv, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r;
    ifM.load_valid = lv; ifM.din = d;
    ifL.load_valid = lv; ifL.din = d;
    @(negedge clk);
    if (ifM.done === 1'b1) doneCntM++;
    if (ifL.done === 1'b1) doneCntL++;
    if (ifM.sout_valid === 1'b1) runM++;
    else begin if (runM > maxRunM) maxRunM = runM; runM = 0; end
    if (ifL.sout_valid === 1'b1) runL++;
    else begin if (runL > maxRunL) maxRunL = runL; runL = 0; end
    checkInst(1'b0, ifM.load_ready, ifM.sout_valid, ifM.sout, ifM.done, r, lv, d);
    checkInst(1'b1, ifL.load_ready, ifL.sout_valid, ifL.sout, ifL.done, r, lv, d);
  endtask

  task automatic clearStats();
    doneCntM = 0; doneCntL = 0; maxRunM = 0; maxRunL = 0; runM = 0; runL = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkStat(input string nm, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    idle(2);
  endtask

  task automatic test_single_msb();
    clearStats();
    applyStimulus(1'b0, 1'b1, 32'hfe34c213);
    idle(34);
    checkStat("single done pulses", doneCntM, 1);
    checkStat("single run length", maxRunM, 32);
  endtask

  task automatic test_back_to_back();
    int  n;
    clearStats();
    applyStimulus(1'b0, 1'b1, 32'hffffffff);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 32'h00000002);
      n++;
    end while (!lastAccept && n < 40);
    if (!lastAccept) begin
      miscompares++;
      $display("[TB] FAIL b2b second accept: got none want accept within 40 cycles");
    end
    idle(35);
    checkStat("b2b done pulses", doneCntM, 2);
    checkStat("b2b run length", maxRunM, 64);
  endtask

  task automatic test_busy_ignore();
    clearStats();
    applyStimulus(1'b0, 1'b1, 32'hffffffff);
    for (int i = 1; i <= 30; i++) applyStimulus(1'b0, logic'(i % 2), 32'h12345678);
    idle(35);
    checkStat("busy done pulses", doneCntM, 1);
    checkStat("busy run length", maxRunM, 32);
  endtask

  task automatic test_reset_mid();
    clearStats();
    applyStimulus(1'b0, 1'b1, 32'hfe34c213);
    idle(10);
    applyStimulus(1'b1, 1'b1, 32'hffffffff);
    applyStimulus(1'b1, 1'b0, 32'h0);
    idle(2);
    checkStat("midreset done pulses", doneCntM, 0);
    applyStimulus(1'b0, 1'b1, 32'h80000001);
    idle(34);
    checkStat("midreset fresh done pulses", doneCntM, 1);
  endtask

  task automatic test_lsb();
    clearStats();
    applyStimulus(1'b0, 1'b1, 32'h00000002);
    idle(34);
    checkStat("lsb done pulses", doneCntL, 1);
    checkStat("lsb run length", maxRunL, 32);
  endtask

  // Test sequence; reset is held from time zero so the first edge clears the DUTs.
  initial begin
    rst = 1'b1;
    ifM.load_valid = 1'b0; ifM.din = '0;
    ifL.load_valid = 1'b0; ifL.din = '0;
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_lsb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
